// File: rtl/onchip_memory_dp.sv
// Dual-slave Avalon-MM on-chip RAM: two ports share one inferred RAM array through a
// round-robin arbiter, with pipelined reads of selectable latency (1 or 2).
module onchip_memory_dp #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 2048,
  parameter int ADDR_W       = 11,
  parameter int READ_LATENCY = 1,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic              s2_waitrequest,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic              req1, req2, grant1, grant2;
  logic              last_s2;
  logic              acc_wr, acc_rd, acc_port, in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic [BE_W-1:0]   acc_be;
  logic [DATA_W-1:0] acc_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p0, tag_p0;
  logic [DATA_W-1:0] rdata_p0;
  logic              vld_f, tag_f;
  logic [DATA_W-1:0] rdata_f;
  logic              primed1, primed2;

  assign req1 = s1_chipselect & (s1_read | s1_write);
  assign req2 = s2_chipselect & (s2_read | s2_write);

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (clken) begin
      if (req1 && (!req2 || last_s2)) grant1 = 1'b1;
      else if (req2)                  grant2 = 1'b1;
    end
  end

  assign s1_waitrequest = req1 & ~grant1;
  assign s2_waitrequest = req2 & ~grant2;

  // Write wins when a master raises read and write together.
  assign acc_port  = grant2;
  assign acc_addr  = grant2 ? s2_address    : s1_address;
  assign acc_be    = grant2 ? s2_byteenable : s1_byteenable;
  assign acc_wdata = grant2 ? s2_writedata  : s1_writedata;
  assign acc_wr    = (grant1 & s1_write) | (grant2 & s2_write);
  assign acc_rd    = (grant1 & s1_read & ~s1_write) | (grant2 & s2_read & ~s2_write);
  assign in_range  = {1'b0, acc_addr} < DEPTH_C;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 last_s2 <= 1'b1;
    else if (grant1 | grant2)  last_s2 <= grant2;
  end

  // ---- stage p0: RAM access on the granted cycle ----
  always_ff @(posedge clk) begin
    if (acc_wr && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) mem[acc_addr][i*8 +: 8] <= acc_wdata[i*8 +: 8];
      end
    end
    if (acc_rd) rdata_p0 <= in_range ? mem[acc_addr] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      tag_p0 <= 1'b0;
    end else if (clken) begin
      vld_p0 <= acc_rd;
      if (acc_rd) tag_p0 <= acc_port;
    end
  end

  // ---- stage p1: optional output register ----
  if (READ_LATENCY == 2) begin : g_out_reg
    logic              vld_p1, tag_p1;
    logic [DATA_W-1:0] rdata_p1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p1 <= 1'b0;
        tag_p1 <= 1'b0;
      end else if (clken) begin
        vld_p1 <= vld_p0;
        tag_p1 <= tag_p0;
      end
    end

    always_ff @(posedge clk) begin
      if (clken) rdata_p1 <= rdata_p0;
    end

    assign vld_f   = vld_p1;
    assign tag_f   = tag_p1;
    assign rdata_f = rdata_p1;
  end else begin : g_no_out_reg
    assign vld_f   = vld_p0;
    assign tag_f   = tag_p0;
    assign rdata_f = rdata_p0;
  end

  // Data registers carry no reset, so each port shows zero until its first response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed1 <= 1'b0;
      primed2 <= 1'b0;
    end else begin
      if (s1_readdatavalid) primed1 <= 1'b1;
      if (s2_readdatavalid) primed2 <= 1'b1;
    end
  end

  assign s1_readdatavalid = vld_f & ~tag_f;
  assign s2_readdatavalid = vld_f & tag_f;
  assign s1_readdata      = (primed1 | s1_readdatavalid) ? rdata_f : '0;
  assign s2_readdata      = (primed2 | s2_readdatavalid) ? rdata_f : '0;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: two instances (2048 words / latency 1 and 1000 words /
// latency 2) share stimulus and are checked every cycle against a behavioural model.
module tb_onchip_memory_dp;

  logic clk = 1'b0;
  logic reset, clken;
  logic        cs [2];
  logic        rd [2];
  logic        wr [2];
  logic [9:0]  ad [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];

  wire wa1, wa2, wb1, wb2, va1, va2, vb1, vb2;
  wire [31:0] da1, da2, db1, db2;
  wire [3:0]        act_w = {wb2, wb1, wa2, wa1};
  wire [3:0]        act_v = {vb2, vb1, va2, va1};
  wire [3:0][31:0]  act_d = {db2, db1, da2, da1};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onchip_memory_dp u_a (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]), .s1_address({1'b0, ad[0]}),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_waitrequest(wa1),
    .s1_readdata(da1), .s1_readdatavalid(va1),
    .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]), .s2_address({1'b0, ad[1]}),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_waitrequest(wa2),
    .s2_readdata(da2), .s2_readdatavalid(va2)
  );

  onchip_memory_dp #(.DATA_W(32), .DEPTH(1000), .ADDR_W(10), .READ_LATENCY(2)) u_b (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]), .s1_address(ad[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_waitrequest(wb1),
    .s1_readdata(db1), .s1_readdatavalid(vb1),
    .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]), .s2_address(ad[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_waitrequest(wb2),
    .s2_readdata(db2), .s2_readdatavalid(vb2)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed { logic v; logic p; logic [31:0] d; } resp_t;
  resp_t       hist     [2][2];
  logic        m_last   [2];
  logic        m_vld    [2][2];
  logic        m_primed [2][2];
  logic [31:0] m_rdata  [2];
  logic [31:0] mmem     [2][1024];
  int depth_m [2] = '{2048, 1000};
  int rl_m    [2] = '{1, 2};

  task automatic check(input string nm, input int inst, input int port,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d s%0d: got %h, expected %h", nm, inst, port + 1, act, exp);
    end
  endtask

  function automatic logic req(input int p);
    return cs[p] && (rd[p] || wr[p]);
  endfunction

  function automatic int winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hist[i][0] = '0;
      hist[i][1] = '0;
      m_last[i]  = 1'b1;
      m_rdata[i] = '0;
      for (int p = 0; p < 2; p++) begin
        m_vld[i][p]    = 1'b0;
        m_primed[i][p] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int g;
      g = clken ? winner(req(0), req(1), m_last[i]) : -1;
      for (int p = 0; p < 2; p++) begin
        int k;
        k = i * 2 + p;
        check("waitrequest", i, p, act_w[k], req(p) && g != p);
        check("readdatavalid", i, p, act_v[k], m_vld[i][p]);
        if (m_vld[i][p])         check("readdata", i, p, act_d[k], m_rdata[i]);
        else if (!m_primed[i][p]) check("readdata_idle", i, p, act_d[k], 32'h0);
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int g, a;
      resp_t nr, o;
      g  = winner(req(0), req(1), m_last[i]);
      nr = '0;
      if (g >= 0) begin
        m_last[i] = g[0];
        a = int'(ad[g]);
        if (wr[g]) begin
          if (a < depth_m[i])
            for (int b = 0; b < 4; b++)
              if (be[g][b]) mmem[i][a][b*8 +: 8] = wd[g][b*8 +: 8];
        end else begin
          nr.v = 1'b1;
          nr.p = g[0];
          nr.d = (a < depth_m[i]) ? mmem[i][a] : 32'h0;
        end
      end
      hist[i][1] = hist[i][0];
      hist[i][0] = nr;
      o = hist[i][rl_m[i] - 1];
      m_vld[i][0] = o.v && !o.p;
      m_vld[i][1] = o.v && o.p;
      if (o.v) begin
        m_rdata[i] = o.d;
        m_primed[i][o.p] = 1'b1;
      end
    end
  endtask

  // Inputs are stable at the falling edge and are what the next rising edge samples.
  always @(negedge clk) begin
    if (reset) model_reset();
    check_outputs();
    if (!reset && clken) model_step();
  end

  // ---------------- stimulus ----------------
  logic [9:0] atab [16] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7,
                            10'd500, 10'd511, 10'd998, 10'd999, 10'd1000, 10'd1001,
                            10'd1010, 10'd1023};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
    end
  endtask

  task automatic access(input int p, input logic r, input logic w, input logic [9:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    bit done;
    done = 1'b0;
    cs[p] = 1'b1; rd[p] = r; wr[p] = w; ad[p] = a; be[p] = b; wd[p] = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = clken && !act_w[p];
      step();
    end
    cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout s%0d: no grant within 50 cycles, required a grant", p + 1);
    end
  endtask

  task automatic read_lit(input int p, input logic [9:0] a, input logic [31:0] expa,
                          input logic [31:0] expb);
    access(p, 1'b1, 1'b0, a, 4'hF, 32'h0);
    @(negedge clk);
    check("lit_rdv_lat1", 0, p, act_v[p], 1);
    check("lit_data_lat1", 0, p, act_d[p], expa);
    check("lit_other_quiet", 0, 1 - p, act_v[1 - p], 0);
    @(negedge clk);
    check("lit_rdv_lat2", 1, p, act_v[2 + p], 1);
    check("lit_data_lat2", 1, p, act_d[2 + p], expb);
    step();
  endtask

  initial begin
    bit st [2];
    reset = 1'b1;
    clken = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cs[p] = 0; rd[p] = 0; wr[p] = 0; ad[p] = '0; be[p] = '0; wd[p] = '0; st[p] = 0;
    end
    step(); step();
    @(negedge clk);
    check("reset_rdv", 0, 0, va1, 0);
    check("reset_data", 0, 0, da1, 32'h0);
    check("reset_data", 1, 1, db2, 32'h0);
    step();
    reset = 1'b0;
    step();

    for (int j = 0; j < 16; j++)
      access(0, 1'b0, 1'b1, atab[j], 4'hF, 32'hC0DE0000 | 32'(atab[j]));

    access(0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    read_lit(0, 10'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    access(0, 1'b0, 1'b1, 10'd7, 4'hF, 32'hAABBCCDD);
    access(0, 1'b0, 1'b1, 10'd7, 4'b0101, 32'h11223344);
    read_lit(1, 10'd7, 32'hAA22CC44, 32'hAA22CC44);

    // Both ports read continuously; s2 went last so s1 takes the first tie.
    cs[0] = 1; rd[0] = 1; ad[0] = 10'd5;
    cs[1] = 1; rd[1] = 1; ad[1] = 10'd7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rr_wait", 0, 0, act_w[0], c % 2);
      check("rr_wait", 0, 1, act_w[1], 1 - c % 2);
      step();
    end
    idle();
    repeat (3) step();

    // Three back-to-back s2 reads seen through the latency-2 instance.
    cs[1] = 1; rd[1] = 1; ad[1] = 10'd5;
    step();
    ad[1] = 10'd7;
    @(negedge clk); check("rl2_not_yet", 1, 1, vb2, 0); step();
    ad[1] = 10'd6;
    @(negedge clk); check("rl2_first", 1, 1, db2, 32'hDEADBEEF); step();
    idle();
    @(negedge clk); check("rl2_second", 1, 1, db2, 32'hAA22CC44); step();
    @(negedge clk); check("rl2_third", 1, 1, db2, 32'hC0DE0006); step();
    @(negedge clk); check("rl2_done", 1, 1, vb2, 0); step();

    // Freeze with a read in flight and a second request waiting.
    access(0, 1'b1, 1'b0, 10'd7, 4'hF, 32'h0);
    clken = 1'b0;
    cs[1] = 1; rd[1] = 1; ad[1] = 10'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("frozen_wait", 0, 1, wa2, 1);
      check("frozen_wait", 1, 1, wb2, 1);
      check("frozen_rdv", 1, 0, vb1, 0);
      step();
    end
    clken = 1'b1;
    @(negedge clk); check("thaw_rdv_pending", 1, 0, vb1, 0); step();
    idle();
    @(negedge clk);
    check("thaw_rdv", 1, 0, vb1, 1);
    check("thaw_data", 1, 0, db1, 32'hAA22CC44);
    step();
    repeat (3) step();

    // Reset one cycle after a read grant drops the read.
    access(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_rdv", 0, 0, va1, 0);
    check("rst_data", 1, 0, db1, 32'h0);
    step(); step();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rdv", 1, 0, vb1, 0);
      check("post_rst_data", 1, 0, db1, 32'h0);
      step();
    end
    read_lit(0, 10'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    // Address 1010 lies past the 1000-word instance but inside the 2048-word one.
    access(0, 1'b0, 1'b1, 10'd1010, 4'hF, 32'h12345678);
    access(1, 1'b0, 1'b1, 10'd999, 4'hF, 32'hCAFEF00D);
    read_lit(0, 10'd1010, 32'h12345678, 32'h00000000);
    read_lit(1, 10'd999, 32'hCAFEF00D, 32'hCAFEF00D);

    // Random traffic; a stalled master keeps its request until granted.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        st[0] = 0; st[1] = 0;
        continue;
      end
      clken = ($urandom_range(0, 9) != 0);
      for (int p = 0; p < 2; p++) begin
        if (!st[p]) begin
          cs[p] = ($urandom_range(0, 3) != 0);
          rd[p] = 1'($urandom_range(0, 1));
          wr[p] = ($urandom_range(0, 2) == 0);
          ad[p] = atab[$urandom_range(0, 15)];
          be[p] = 4'($urandom);
          wd[p] = $urandom;
        end
      end
      @(negedge clk);
      st[0] = wa1;
      st[1] = wa2;
      step();
    end
    idle();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2 ms, required completion");
    $fatal(1);
  end

endmodule

// File: doc/onchip_memory_dp.md
Name: onchip_memory_dp

Overview:
- Parametrised successor to the single-port Avalon-MM on-chip RAM.
- Exposes two Avalon-MM slaves, s1 and s2, over one shared RAM array, with round-robin arbitration.
- Provides pipelined reads with readdatavalid, waitrequest back-pressure, and a selectable read latency.
- Sits between the Nios II instruction/data masters and local program/data storage; contents are inferred RAM, not reset.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 2048, number of words; need not be a power of 2.
- ADDR_W, 11, word address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LATENCY, 1, cycles from grant to readdatavalid; legal values are 1 or 2 (2 adds an output register).
- BE_W, DATA_W/8, byteenable width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clken  in  1  global clock enable; low freezes the block
- s1_chipselect  in  1  port 1 select
- s1_read  in  1  port 1 read request
- s1_write  in  1  port 1 write request
- s1_address  in  ADDR_W  port 1 word address
- s1_byteenable  in  BE_W  port 1 byte lanes
- s1_writedata  in  DATA_W  port 1 write data
- s1_waitrequest  out  1  port 1 stall
- s1_readdata  out  DATA_W  port 1 read data
- s1_readdatavalid  out  1  port 1 read data strobe
- s2_* : identical set to s1_*, for port 2

Behaviour:
- Request: reqN = sN_chipselect & (sN_read | sN_write). If read and write are both set, the access is treated as a write and produces no readdatavalid.
- Grant: at most one access per cycle, and only when clken=1.
  - One port requesting: that port is granted.
  - Both requesting: the port not granted most recently wins.
  - The last-grant pointer resets to s2, so s1 wins the first tie.
- sN_waitrequest = reqN & ~grantN, combinational. A stalled master holds its signals; the block does not latch them.
- Write, on the granted cycle at the clk edge: each byte lane i with byteenable[i]=1 is written. Lanes with byteenable=0 keep their old value.
- Read:
  - The address is sampled on the granted cycle.
  - sN_readdata and sN_readdatavalid=1 appear READ_LATENCY cycles later, for exactly one cycle, on the requesting port only.
  - Back-to-back reads give one result per cycle; ordering is preserved per port.
- Read after write, same address, next cycle: returns the new data. There is no same-cycle read/write hazard, because the block makes one access per cycle.
- Out-of-range address (address >= DEPTH): writes are ignored; reads return all zeros with a normal readdatavalid.
- clken=0:
  - No grants; waitrequest = req on both ports.
  - The read pipeline holds its state, so a pending readdatavalid is delayed, not lost.
  - Outputs hold their values.
- sN_readdata is not required to be zero when readdatavalid=0, except after reset.
- Reset (asynchronous):
  - s1/s2_readdatavalid = 0 and s1/s2_readdata = 0.
  - Pipeline valid bits are cleared and the last-grant pointer is set to s2.
  - Reads in flight at reset are dropped, with no readdatavalid afterwards.
  - RAM contents are unaffected.
- Pipeline tags carry the port id, so each response routes to its requester.

Test Plan:
- Reset, then s1 writes 0xDEADBEEF to address 5 with be=4'hF; s1 reads address 5 -> s1_readdatavalid pulses 1 cycle after grant (READ_LATENCY=1) with 0xDEADBEEF, and s2_readdatavalid stays 0.
- Byte lanes: write 0xAABBCCDD to address 7 with be=4'hF, then write 0x11223344 with be=4'b0101; read -> 0xAA22CC44.
- Contention: s1 and s2 both read continuously for 4 cycles -> grants alternate s1,s2,s1,s2; each waitrequest is high on alternate cycles; each port receives its own 2 results in order.
- READ_LATENCY=2: s2 reads 3 addresses back-to-back -> three consecutive readdatavalid pulses starting 2 cycles after the first grant, with the correct data in order.
- clken low for 3 cycles while a read is pending -> readdatavalid is delayed by 3 cycles with the data intact; requests see waitrequest=1 throughout.
- Reset asserted 1 cycle after a read grant with READ_LATENCY=2 -> no readdatavalid ever appears; readdata=0; the data written before reset is still readable afterwards.
- Out-of-range with DEPTH=1000, ADDR_W=10: write to address 1010, then read it -> returns 0x00000000; address 999 is unaffected.
